wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile.sv | 111 +++++++++++
 tb/tb_wb_regfile.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Write-back stage register plus a 2-read/1-write register file.
// The WB register captures the MEM-stage result each cycle (or a bubble
// when stalled); the following edge commits it to the array. Reads are
// combinational and bypass both the MEM and WB stages, youngest first.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic              mem_wreg,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [ADDR_W-1:0] wb_wd,
  output logic              wb_wreg,
  output logic [DATA_W-1:0] wb_wdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [ADDR_W-1:0] wb_wd_reg;
  logic              wb_wreg_reg;
  logic [DATA_W-1:0] wb_wdata_reg;

  // Current value of every entry; entry 0 is a hard-wired zero.
  logic [DATA_W-1:0] entries [DEPTH];

  // WB pipeline register: load the MEM stage, or a bubble while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_wd_reg    <= '0;
      wb_wreg_reg  <= 1'b0;
      wb_wdata_reg <= '0;
    end else if (stall) begin
      wb_wd_reg    <= '0;
      wb_wreg_reg  <= 1'b0;
      wb_wdata_reg <= '0;
    end else begin
      wb_wd_reg    <= mem_wd;
      wb_wreg_reg  <= mem_wreg;
      wb_wdata_reg <= mem_wdata;
    end
  end

  assign wb_wd    = wb_wd_reg;
  assign wb_wreg  = wb_wreg_reg;
  assign wb_wdata = wb_wdata_reg;

  assign entries[0] = '0;

  // Entries need an asynchronous clear, so they are built from flops
  // rather than an inferred RAM. The write is independent of stall: the
  // instruction already in WB must retire even if MEM is held.
  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_entry
      logic [DATA_W-1:0] value_reg;

      // Commit the WB-stage result when it targets this entry.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          value_reg <= '0;
        end else if (wb_wreg_reg && (wb_wd_reg == ADDR_W'(gi))) begin
          value_reg <= wb_wdata_reg;
        end
      end

      assign entries[gi] = value_reg;
    end
  endgenerate

  logic [1:0]              re_vec;
  logic [1:0][ADDR_W-1:0]  addr_vec;
  logic [1:0][DATA_W-1:0]  data_vec;

  assign re_vec   = {re2, re1};
  assign addr_vec = {raddr2, raddr1};
  assign rdata1   = data_vec[0];
  assign rdata2   = data_vec[1];

  // Identical, independent read ports.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic [DATA_W-1:0] rd_value;

      // Resolve the read: reset, disable and address 0 force zero; then
      // MEM (younger) beats WB, which beats the array.
      always_comb begin
        rd_value = '0;
        if (rst || !re_vec[gi] || (addr_vec[gi] == '0)) begin
          rd_value = '0;
        end else if (mem_wreg && (mem_wd == addr_vec[gi])) begin
          rd_value = mem_wdata;
        end else if (wb_wreg_reg && (wb_wd_reg == addr_vec[gi])) begin
          rd_value = wb_wdata_reg;
        end else begin
          rd_value = entries[addr_vec[gi]];
        end
      end

      assign data_vec[gi] = rd_value;
    end
  endgenerate

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios followed by
// randomized traffic, all checked against an array-based reference model.
module tb_wb_regfile;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              stall = 1'b0;
  logic [ADDR_W-1:0] mem_wd = '0;
  logic              mem_wreg = 1'b0;
  logic [DATA_W-1:0] mem_wdata = '0;
  logic              re1 = 1'b0;
  logic [ADDR_W-1:0] raddr1 = '0;
  logic              re2 = 1'b0;
  logic [ADDR_W-1:0] raddr2 = '0;
  logic [DATA_W-1:0] rdata1, rdata2;
  logic [ADDR_W-1:0] wb_wd;
  logic              wb_wreg;
  logic [DATA_W-1:0] wb_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the register contents and the instruction sitting in WB.
  logic [DATA_W-1:0] ref_regs [DEPTH];
  logic [ADDR_W-1:0] ref_wd;
  logic              ref_wreg;
  logic [DATA_W-1:0] ref_wdata;

  wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .re1(re1), .raddr1(raddr1), .re2(re2), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ref_clear();
    for (int i = 0; i < DEPTH; i++) ref_regs[i] = '0;
    ref_wd = '0; ref_wreg = 1'b0; ref_wdata = '0;
  endtask

  // What a reader should see: the newest pending value for the address.
  function automatic logic [DATA_W-1:0] ref_read(input logic re, input logic [ADDR_W-1:0] a);
    if (rst || !re || a == 0) return '0;
    if (mem_wreg && mem_wd == a) return mem_wdata;
    if (ref_wreg && ref_wd == a) return ref_wdata;
    return ref_regs[a];
  endfunction

  // Advance one clock: retire WB into the model array, then move MEM into WB.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      if (ref_wreg && ref_wd != 0) ref_regs[ref_wd] = ref_wdata;
      if (stall) begin
        ref_wd = '0; ref_wreg = 1'b0; ref_wdata = '0;
      end else begin
        ref_wd = mem_wd; ref_wreg = mem_wreg; ref_wdata = mem_wdata;
      end
    end
    #1;
  endtask

  task automatic set_mem(input logic s, input int wd, input logic we, input logic [DATA_W-1:0] d);
    stall = s; mem_wd = ADDR_W'(wd); mem_wreg = we; mem_wdata = d;
  endtask

  task automatic set_rd(input logic e1, input int a1, input logic e2, input int a2);
    re1 = e1; raddr1 = ADDR_W'(a1); re2 = e2; raddr2 = ADDR_W'(a2);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".wb_wd"},    64'(wb_wd),    64'(ref_wd));
    chk({tag, ".wb_wreg"},  64'(wb_wreg),  64'(ref_wreg));
    chk({tag, ".wb_wdata"}, 64'(wb_wdata), 64'(ref_wdata));
    chk({tag, ".rdata1"},   64'(rdata1),   64'(ref_read(re1, raddr1)));
    chk({tag, ".rdata2"},   64'(rdata2),   64'(ref_read(re2, raddr2)));
  endtask

  initial begin
    ref_clear();
    set_rd(1, 5, 1, 6);
    #2;
    check_all("reset_hold");
    tick();
    rst = 1'b0;
    #1;
    check_all("post_reset");

    // Basic write then read back from the array.
    set_mem(0, 5, 1, 32'h12345678);
    tick();
    set_mem(0, 0, 0, 0);
    tick(); tick();
    set_rd(1, 5, 0, 0);
    #2;
    chk("basic_rd", 64'(rdata1), 64'h12345678);
    check_all("basic");

    // Forwarding priority on entry 7.
    set_mem(0, 7, 1, 32'h11);
    tick();
    set_mem(0, 7, 1, 32'h22);
    tick();
    set_mem(0, 7, 1, 32'h33);
    set_rd(1, 7, 1, 7);
    #2;
    chk("fwd_mem", 64'(rdata1), 64'h33);
    chk("fwd_same_port", 64'(rdata2), 64'h33);
    mem_wreg = 1'b0;
    #1;
    chk("fwd_wb", 64'(rdata1), 64'h22);
    check_all("fwd_wb");
    tick();
    tick();
    chk("fwd_array", 64'(rdata1), 64'h22);
    check_all("fwd_array");

    // Register 0 is never written and always reads zero.
    set_rd(1, 0, 1, 0);
    set_mem(0, 0, 1, 32'hFFFFFFFF);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("reg0_rd", 64'(rdata2), 64'h0);
      tick();
    end
    set_mem(0, 0, 0, 0);
    tick();
    chk("reg0_after", 64'(rdata2), 64'h0);

    // Stall inserts a bubble; the stalled MEM contents never land.
    set_mem(1, 9, 1, 32'hAA);
    tick();
    chk("stall_wreg", 64'(wb_wreg), 64'h0);
    chk("stall_wd", 64'(wb_wd), 64'h0);
    set_mem(0, 0, 0, 0);
    tick(); tick();
    set_rd(1, 9, 0, 0);
    #1;
    chk("stall_rd", 64'(rdata1), 64'h0);

    // Asynchronous reset discards the array and the pending WB write.
    set_mem(0, 3, 1, 32'h5); tick();
    set_mem(0, 4, 1, 32'h6); tick();
    set_mem(0, 3, 1, 32'h7); tick();
    set_mem(0, 0, 0, 0);
    set_rd(1, 3, 1, 4);
    #1;
    chk("pre_rst_rd1", 64'(rdata1), 64'h7);
    chk("pre_rst_rd2", 64'(rdata2), 64'h6);
    rst = 1'b1;
    #1;
    ref_clear();
    chk("rst_wreg", 64'(wb_wreg), 64'h0);
    chk("rst_wdata", 64'(wb_wdata), 64'h0);
    chk("rst_rd1", 64'(rdata1), 64'h0);
    chk("rst_rd2", 64'(rdata2), 64'h0);
    rst = 1'b0;
    #1;
    chk("rel_rd1", 64'(rdata1), 64'h0);
    chk("rel_rd2", 64'(rdata2), 64'h0);
    tick();
    check_all("rst_after");

    // Read enable gates the port.
    set_mem(0, 2, 1, 32'hBEEF); tick();
    set_mem(0, 0, 0, 0); tick(); tick();
    set_rd(0, 2, 1, 2);
    #1;
    chk("re_off", 64'(rdata1), 64'h0);
    re1 = 1'b1;
    #1;
    chk("re_on", 64'(rdata1), 64'hBEEF);

    // Randomized traffic; a narrow address range half the time forces hazards.
    for (int n = 0; n < 600; n++) begin
      tick();
      set_mem(($urandom_range(0, 3) == 0),
              ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, DEPTH - 1),
              ($urandom_range(0, 3) != 0), $urandom());
      set_rd(($urandom_range(0, 7) != 0),
             ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, DEPTH - 1),
             ($urandom_range(0, 7) != 0),
             ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, DEPTH - 1));
      #2;
      check_all("rand");
      if ($urandom_range(0, 63) == 0) begin
        rst = 1'b1;
        #1;
        ref_clear();
        check_all("rand_rst");
        rst = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
